// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the modulo-N counter monitor.
package count_mon_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  // Value the counter must show one edge after it sampled (prev, en).
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] prev,
                                                  input logic en,
                                                  input int m);
    if (!en) return prev;
    if (int'(prev) == m - 1) return '0;
    return prev + CNT_W'(1);
  endfunction

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Receive-side checker for a modulo-N enable counter: sticky error, lock and wrap count.
// Optional BAD_EXP/BAD_GOT capture of the first violation is enabled by COUNT_MON_CAPTURE_EN.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int modulo_contador = 10,
  parameter int WRAP_W          = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              ENABLE,
  input  logic [CNT_W-1:0]  COUNT_IN,
  input  logic              CLR_ERR,
  output logic              ERROR,
  output logic              WRAP_PULSE,
  output logic [WRAP_W-1:0] WRAPS,
  output logic              LOCKED
`ifdef COUNT_MON_CAPTURE_EN
  ,
  output logic [CNT_W-1:0]  BAD_EXP,
  output logic [CNT_W-1:0]  BAD_GOT
`endif
);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [CNT_W-1:0] prev;
  logic             en_d;
  logic [CNT_W-1:0] exp_val;
  logic             in_range;
  logic             violation;
  logic             wrap_hit;
  logic             wrap_pulse_q;

  assign exp_val   = next_count(prev, en_d, modulo_contador);
  assign in_range  = int'(COUNT_IN) < modulo_contador;
  assign violation = !in_range || (COUNT_IN != exp_val);

  always_comb begin
    state_nxt = state;
    wrap_hit  = 1'b0;
    case (state)
      SYNC:  state_nxt = in_range ? TRACK : FAULT;
      TRACK: begin
        if (violation) begin
          state_nxt = FAULT;
        end else begin
          state_nxt = TRACK;
          wrap_hit  = en_d && (int'(prev) == modulo_contador - 1) && (COUNT_IN == '0);
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = SYNC;
    endcase
    // A clear always wins: re-lock from scratch and ignore this edge's sample.
    if (CLR_ERR) begin
      state_nxt = SYNC;
      wrap_hit  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= SYNC;
      prev         <= '0;
      en_d         <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      prev         <= COUNT_IN;
      en_d         <= ENABLE;
      wrap_pulse_q <= wrap_hit;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wraps (
    .CLK  (CLK),
    .RSTn (RSTn),
    .inc  (wrap_hit),
    .q    (WRAPS)
  );

`ifdef COUNT_MON_CAPTURE_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      BAD_EXP <= '0;
      BAD_GOT <= '0;
    end else if (CLR_ERR) begin
      BAD_EXP <= '0;
      BAD_GOT <= '0;
    end else if ((state != FAULT) && (state_nxt == FAULT)) begin
      BAD_EXP <= exp_val;
      BAD_GOT <= COUNT_IN;
    end
  end
`endif

  assign ERROR      = (state == FAULT);
  assign LOCKED     = (state == TRACK);
  assign WRAP_PULSE = wrap_pulse_q;

endmodule
